// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM state type and legality helpers shared by the load/store unit
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] ofs);
      return ((funct3 == F3_H || funct3 == F3_HU) && ofs[0]) || (funct3 == F3_W && ofs != 2'b00);
   endfunction
   function automatic logic is_legal(input logic is_store, input logic [2:0] funct3);
      return is_store ? (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W)
                      : (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W || funct3 == F3_BU || funct3 == F3_HU);
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering/strobes and load lane extraction with sign/zero extension
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  ofs,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_word,
   output logic [3:0]  st_strb,
   output logic [31:0] st_lanes,
   output logic [31:0] ld_data
);
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        sx;
   always_comb begin
      st_strb  = funct3 == F3_B ? 4'b0001 << ofs : funct3 == F3_H ? (ofs[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      st_lanes = funct3 == F3_B ? {4{st_data[7:0]}} : funct3 == F3_H ? {2{st_data[15:0]}} : st_data;
      ld_byte  = ld_word[{ofs, 3'b000} +: 8];
      ld_half  = ofs[1] ? ld_word[31:16] : ld_word[15:0];
      sx       = funct3 == F3_B || funct3 == F3_H;
      ld_data  = (funct3 == F3_B || funct3 == F3_BU) ? {{24{sx & ld_byte[7]}}, ld_byte}
               : (funct3 == F3_H || funct3 == F3_HU) ? {{16{sx & ld_half[15]}}, ld_half}
               : ld_word;
   end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between the ALU and a valid/ready data-memory bus
module lsu
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        fault,
   output logic [31:0] fault_addr
);
   state_t      state, state_nx;
   logic [2:0]  f3_q;
   logic [1:0]  ofs_q;
   logic [4:0]  rd_q;
   logic        accept, bad;
   logic [3:0]  al_strb;
   logic [31:0] al_lanes, al_rdata;
   assign req_ready = state == IDLE;
   assign mem_valid = state == REQ;
   assign wb_valid  = state == RESP;
   assign accept    = req_valid && req_ready;
   assign bad       = !is_legal(req_is_store, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
   // One aligner serves both directions: live request fields in IDLE, latched ones while a load is pending
   lsu_align u_align (
      .funct3   (req_ready ? req_funct3 : f3_q),
      .ofs      (req_ready ? req_addr[1:0] : ofs_q),
      .st_data  (req_wdata),
      .ld_word  (mem_rdata),
      .st_strb  (al_strb),
      .st_lanes (al_lanes),
      .ld_data  (al_rdata)
   );
   always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE   ? (accept && !bad ? REQ : IDLE)
               : state == REQ    ? (mem_ready ? (mem_we ? IDLE : WAIT_R) : REQ)
               : state == WAIT_R ? (mem_rvalid ? RESP : WAIT_R)
               : IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wstrb  <= '0;
         mem_wdata  <= '0;
         wb_rd      <= '0;
         wb_data    <= '0;
         fault      <= 1'b0;
         fault_addr <= '0;
         f3_q       <= '0;
         ofs_q      <= '0;
         rd_q       <= '0;
      end else begin
         fault <= accept && bad;
         if (accept && bad)
            fault_addr <= req_addr;
         if (accept && !bad) begin
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_we    <= req_is_store;
            mem_wstrb <= req_is_store ? al_strb : 4'b0000;
            mem_wdata <= req_is_store ? al_lanes : 32'h0;
            f3_q      <= req_funct3;
            ofs_q     <= req_addr[1:0];
            rd_q      <= req_rd;
         end
         if (state == WAIT_R && mem_rvalid) begin
            wb_rd   <= rd_q;
            wb_data <= al_rdata;
         end
      end
   end
endmodule
